// File: rtl/ni_local.sv
// ni_local -- network interface between a processing element (PE) and the
// local port of a mesh router.
//
// Injection: the PE offers {dst, data}; the block builds a 40-bit flit
//   [39:38] dst | [37:36] LOCAL_ID | [35:34] seq | [33]=1 | [32]=0 | [31:0] data
// holds it in a register and writes it to the router local input FIFO with a
// single-cycle strobe once that FIFO is not full (one flit per two cycles).
//
// Ejection: flits from the router local output are buffered in an EJ_DEPTH
// deep FIFO and presented to the PE. Back-pressure to the router is raised two
// slots early; flits arriving while full are dropped and flagged (ej_ovf).
//
// Optional feature: define NI_SEQ_EN to fill the seq field with a 2-bit
// counter that advances on each write strobe; otherwise the field is 2'b00.
//
// Parameters:
//   LOCAL_ID        node coordinate inserted as the flit source field
//   EJ_DEPTH        ejection FIFO depth (power of two, >= 4)
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   pe_tx_valid/ready, pe_tx_dst, pe_tx_data   PE injection handshake
//   wr_en_local, wdata_local, full_local       router local input FIFO
//   ej_valid, ej_data, next_full_local         router local output
//   pe_rx_valid/ready, pe_rx_src, pe_rx_data   PE ejection handshake
//   ej_ovf          sticky ejection overflow flag

module ni_local #(
  parameter logic [1:0] LOCAL_ID = 2'b00,
  parameter int         EJ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pe_tx_valid,
  output logic        pe_tx_ready,
  input  logic [1:0]  pe_tx_dst,
  input  logic [31:0] pe_tx_data,
  output logic        wr_en_local,
  output logic [39:0] wdata_local,
  input  logic        full_local,
  input  logic        ej_valid,
  input  logic [39:0] ej_data,
  output logic        next_full_local,
  output logic        pe_rx_valid,
  input  logic        pe_rx_ready,
  output logic [1:0]  pe_rx_src,
  output logic [31:0] pe_rx_data,
  output logic        ej_ovf
);

  localparam int AW = $clog2(EJ_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(EJ_DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(EJ_DEPTH - 2);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [39:0] r_flit;
  logic [1:0]  w_seq;
  logic        w_accept;
  logic        w_wr;

  // Injection FSM decode. Both the ready and the write strobe are masked by
  // rst_n so a flit pending during reset is discarded without a strobe.
  always_comb begin
    w_state_next = r_state;
    pe_tx_ready  = 1'b0;
    w_accept     = 1'b0;
    w_wr         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        pe_tx_ready = rst_n;
        if (rst_n && pe_tx_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        w_wr = rst_n && !full_local;
        if (w_wr) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign wr_en_local = w_wr;
  assign wdata_local = r_flit;

  // Injection state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flit register: captured on accept and held unchanged while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flit <= '0;
    end else if (w_accept) begin
      r_flit <= {pe_tx_dst, LOCAL_ID, w_seq, 2'b10, pe_tx_data};
    end
  end

`ifdef NI_SEQ_EN
  logic [1:0] r_seq;

  // Sequence counter advances once per flit actually written to the router.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seq <= 2'b00;
    end else if (w_wr) begin
      r_seq <= r_seq + 2'b01;
    end
  end

  assign w_seq = r_seq;
`else
  assign w_seq = 2'b00;
`endif

  // ---------------- ejection FIFO ----------------
  logic [39:0]   r_mem [0:EJ_DEPTH-1];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_nfull;
  logic          r_ovf;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [39:0]   w_head;
  logic          w_unused;

  assign w_full      = (r_count == DEPTH_C);
  assign pe_rx_valid = (r_count != '0);
  assign w_pop       = pe_rx_valid && pe_rx_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO succeeds.
  assign w_push      = ej_valid && (!w_full || w_pop);

  assign w_head      = r_mem[r_rd_ptr];
  assign pe_rx_src   = w_head[37:36];
  assign pe_rx_data  = w_head[31:0];
  assign w_unused    = &{1'b0, w_head[39:38], w_head[35:32]};

  assign next_full_local = r_nfull;
  assign ej_ovf          = r_ovf;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Storage array; no reset needed since entries are only read when counted.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= ej_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth. The back-pressure flag
  // is computed from the next count so it is asserted in the same cycle the
  // occupancy reaches the threshold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_nfull  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_nfull <= (w_count_next >= THRESH_C);
      if (ej_valid && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule
